unsadd_win_ctrl: RTL and testbench
==================================

UNSADD_WIN_CTRL -- requirements
Module: unsadd_win_ctrl

Interface
REQ-001 SHALL have parameter WIN_LEN, default 256, meaning bitstream cycles per computation window; legal range 1..4096.
REQ-002 SHALL have parameter CNT_W, default 13, meaning result width; CNT_W >= clog2(WIN_LEN+1).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, meaning request to begin one window; sampled only in IDLE, or in DONE on the handshake cycle.
REQ-006 SHALL have port abort, input, 1, meaning cancel the window in progress.
REQ-007 SHALL have port add_out, input, 1, meaning output bit of the non-scaled unary adder datapath.
REQ-008 SHALL have port clr_acc, output, 1, meaning one-cycle clear to the adder's theory and actual one-buffers.
REQ-009 SHALL have port en, output, 1, meaning adder and input bitstreams advance this cycle.
REQ-010 SHALL have port busy, output, 1, meaning state is not IDLE.
REQ-011 SHALL have port result, output, CNT_W, meaning count of add_out ones over the completed window.
REQ-012 SHALL have port res_valid, output, 1, meaning result is held and valid.
REQ-013 SHALL have port res_ready, input, 1, meaning the consumer accepts result.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, RUN, DONE, all registered.
REQ-015 IDLE: start=1 -> CLEAR next cycle; otherwise the FSM SHALL stay in IDLE.
REQ-016 CLEAR: clr_acc SHALL be 1 for exactly this one cycle, en=0, the ones counter and the cycle counter SHALL be zeroed, and the FSM SHALL go to RUN.
REQ-017 RUN: en SHALL be 1; on each RUN cycle, add_out=1 SHALL increment the ones counter; the cycle counter SHALL increment each cycle.
REQ-018 RUN SHALL last exactly WIN_LEN cycles; after the cycle with cycle counter = WIN_LEN-1, the FSM SHALL go to DONE, and result SHALL be loaded with the final count including that cycle's add_out.
REQ-019 DONE: res_valid SHALL be 1, result SHALL be held stable, and en=0 until the handshake res_valid and res_ready.
REQ-020 On the handshake cycle, start=1 SHALL go to CLEAR (back-to-back window); otherwise the FSM SHALL go to IDLE; res_valid SHALL drop the next cycle in both cases.
REQ-021 start in CLEAR, in RUN, or in DONE without a handshake SHALL be ignored and not queued.
REQ-022 abort=1 in CLEAR or RUN SHALL go to IDLE next cycle with en=0, res_valid=0, and result unchanged; abort SHALL have priority over window completion on the same cycle.
REQ-023 abort in IDLE or DONE SHALL have no effect.
REQ-024 The ones counter SHALL NOT wrap, because the count is at most WIN_LEN by construction; the cycle counter SHALL be clog2(WIN_LEN) bits wide with no wrap inside a window.
REQ-025 For WIN_LEN=1, RUN SHALL last exactly one cycle.
REQ-026 Latency from start (IDLE) to res_valid SHALL be WIN_LEN+2 cycles.
REQ-027 busy SHALL be 1 in CLEAR, RUN and DONE.

Reset
REQ-028 With rst=1 at a clock edge, the FSM SHALL go to IDLE, clr_acc=0, en=0, busy=0, res_valid=0, result=0, and both counters SHALL be 0.
REQ-029 Reset mid-RUN or mid-DONE SHALL discard the window; no result SHALL be presented.
REQ-030 The first start SHALL be honoured on the first cycle after rst deasserts.

Verification
REQ-031 The bench SHALL cover: WIN_LEN=256, start pulse, add_out=1 every other RUN cycle -> clr_acc for 1 cycle, en for 256 cycles, res_valid at cycle 258, result=128.
REQ-032 The bench SHALL cover: WIN_LEN=256, add_out=1 constantly -> result=256, with no wrap in 13 bits.
REQ-033 The bench SHALL cover: res_ready held 0 for 10 cycles in DONE -> result and res_valid stable, en=0; start pulses during those cycles ignored.
REQ-034 The bench SHALL cover: handshake with start=1 on the same cycle -> CLEAR next cycle, new window with no IDLE cycle, counter re-zeroed.
REQ-035 The bench SHALL cover: abort at RUN cycle 100, including abort on the final RUN cycle -> IDLE, res_valid never asserted, result keeps its previous value.
REQ-036 The bench SHALL cover: rst at RUN cycle 50, then start -> all outputs 0 after reset, and the fresh window completes with the correct count.

Source files
------------

// File: rtl/unsadd_win_ctrl.sv
// unsadd_win_ctrl: window controller for a non-scaled unary adder.
// Clears the adder, runs it for WIN_LEN bitstream cycles and counts the ones
// on add_out. The count is then presented until the consumer takes it.
module unsadd_win_ctrl #(
    parameter int WIN_LEN = 256,
    parameter int CNT_W   = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             add_out,
    output logic             clr_acc,
    output logic             en,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             res_valid,
    input  logic             res_ready
);

    // The cycle counter indexes 0..WIN_LEN-1; keep at least one bit so WIN_LEN=1 works.
    localparam int CYC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] ones_d;
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] cyc_d;
    logic             last_cyc;
    logic             handshake;

    // Next counter values and the window-end / handshake conditions.
    always_comb begin
        ones_d    = ones_q + CNT_W'(add_out);
        cyc_d     = cyc_q + CYC_W'(1);
        last_cyc  = (cyc_q == LAST_CYC);
        handshake = res_valid & res_ready;
    end

    // Window FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_acc   <= 1'b0;
            en        <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            result    <= '0;
            ones_q    <= '0;
            cyc_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    en        <= 1'b0;
                    res_valid <= 1'b0;
                    if (start) begin
                        state_q <= CLEAR;
                        clr_acc <= 1'b1;
                        busy    <= 1'b1;
                        ones_q  <= '0;
                        cyc_q   <= '0;
                    end else begin
                        clr_acc <= 1'b0;
                        busy    <= 1'b0;
                    end
                end

                CLEAR: begin
                    // clr_acc is a single-cycle pulse; counters stay zeroed here.
                    clr_acc <= 1'b0;
                    ones_q  <= '0;
                    cyc_q   <= '0;
                    if (abort) begin
                        state_q <= IDLE;
                        en      <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        state_q <= RUN;
                        en      <= 1'b1;
                    end
                end

                RUN: begin
                    // Abort wins over completion on the final cycle.
                    if (abort) begin
                        state_q <= IDLE;
                        en      <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        ones_q <= ones_d;
                        if (last_cyc) begin
                            // Final count includes this cycle's add_out bit.
                            state_q   <= DONE;
                            en        <= 1'b0;
                            result    <= ones_d;
                            res_valid <= 1'b1;
                        end else begin
                            cyc_q <= cyc_d;
                        end
                    end
                end

                DONE: begin
                    if (handshake) begin
                        res_valid <= 1'b0;
                        if (start) begin
                            // Back-to-back window without passing through IDLE.
                            state_q <= CLEAR;
                            clr_acc <= 1'b1;
                            ones_q  <= '0;
                            cyc_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    clr_acc   <= 1'b0;
                    en        <= 1'b0;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unsadd_win_ctrl.sv
// Directed testbench for unsadd_win_ctrl with WIN_LEN=256, CNT_W=13.
module tb_unsadd_win_ctrl;

    localparam int WIN_LEN = 256;
    localparam int CNT_W   = 13;
    localparam int MAX_EDGES = 400;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic             add_out;
    logic             clr_acc;
    logic             en;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             res_valid;
    logic             res_ready;

    int vec_cnt;
    int err_cnt;

    unsadd_win_ctrl #(
        .WIN_LEN (WIN_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .add_out   (add_out),
        .clr_acc   (clr_acc),
        .en        (en),
        .busy      (busy),
        .result    (result),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pat_bit(input int pat, input int idx);
        case (pat)
            0:       return (idx % 2) == 0;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return (idx % 4) == 0;
        endcase
    endfunction

    // Runs one window until res_valid (bounded). With do_start=0 the DUT is
    // assumed to be in CLEAR already, one edge after the start was taken.
    task automatic run_window(input int pat, input bit do_start,
                              output int n_edges, output int n_en,
                              output int n_clr, output int n_ones);
        int run_idx;
        n_edges = 0; n_en = 0; n_clr = 0; n_ones = 0; run_idx = 0;
        if (do_start) begin
            start = 1'b1;
            add_out = 1'b0;
            step();
            start = 1'b0;
        end
        n_edges = 1;
        vec_cnt++;
        if (clr_acc !== 1'b1 || en !== 1'b0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL clear_cycle: clr_acc=%b en=%b busy=%b required 1 0 1", clr_acc, en, busy);
        end
        while (n_edges < MAX_EDGES && res_valid !== 1'b1) begin
            if (clr_acc === 1'b1) n_clr++;
            if (en === 1'b1) begin
                n_en++;
                add_out = pat_bit(pat, run_idx);
                if (add_out) n_ones++;
                run_idx++;
            end else begin
                add_out = 1'b0;
            end
            step();
            n_edges++;
        end
        add_out = 1'b0;
        vec_cnt++;
        if (res_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL window_timeout: res_valid=%b after %0d edges, required 1", res_valid, n_edges);
        end
    endtask

    task automatic handshake_to_idle(input string name);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        vec_cnt++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_handshake: res_valid=%b busy=%b required 0 0", name, res_valid, busy);
        end
    endtask

    // Starts a window and stops in RUN at index nrun with add_out held at addv.
    task automatic start_and_run(input int nrun, input logic addv);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < nrun; i++) begin
            add_out = addv;
            step();
        end
        add_out = 1'b0;
        vec_cnt++;
        if (en !== 1'b1 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL run_reached: en=%b busy=%b required 1 1", en, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; add_out = 1'b0; res_ready = 1'b0;
        step();
        step();
        vec_cnt++;
        if ({clr_acc, en, busy, res_valid} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_ctrl: clr/en/busy/vld=%b required 0000", {clr_acc, en, busy, res_valid});
        end
        vec_cnt++;
        if (result !== '0) begin
            err_cnt++;
            $display("FAIL reset_result: got %0d required 0", result);
        end
        rst = 1'b0;
    endtask

    // First start on the first edge after reset release; alternating add_out.
    task automatic test_every_other();
        int ne, nen, nclr, nones;
        run_window(0, 1'b1, ne, nen, nclr, nones);
        vec_cnt++;
        if (ne !== 258) begin err_cnt++; $display("FAIL eo_latency: got %0d required 258", ne); end
        vec_cnt++;
        if (nen !== 256) begin err_cnt++; $display("FAIL eo_en_cycles: got %0d required 256", nen); end
        vec_cnt++;
        if (nclr !== 1) begin err_cnt++; $display("FAIL eo_clr_cycles: got %0d required 1", nclr); end
        vec_cnt++;
        if (result !== 13'd128) begin err_cnt++; $display("FAIL eo_result: got %0d required 128", result); end
        vec_cnt++;
        if (en !== 1'b0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL eo_done_state: en=%b busy=%b required 0 1", en, busy);
        end
        handshake_to_idle("eo");
    endtask

    task automatic test_all_ones();
        int ne, nen, nclr, nones;
        run_window(1, 1'b1, ne, nen, nclr, nones);
        vec_cnt++;
        if (result !== 13'd256) begin err_cnt++; $display("FAIL ones_result: got %0d required 256", result); end
        vec_cnt++;
        if (nen !== 256) begin err_cnt++; $display("FAIL ones_en_cycles: got %0d required 256", nen); end
        handshake_to_idle("ones");
    endtask

    task automatic test_stall();
        int ne, nen, nclr, nones;
        run_window(3, 1'b1, ne, nen, nclr, nones);
        vec_cnt++;
        if (result !== 13'd64) begin err_cnt++; $display("FAIL stall_result: got %0d required 64", result); end
        for (int i = 0; i < 10; i++) begin
            res_ready = 1'b0;
            start = (i % 2) == 1;
            step();
            vec_cnt++;
            if (res_valid !== 1'b1 || result !== 13'd64 || en !== 1'b0 || clr_acc !== 1'b0) begin
                err_cnt++;
                $display("FAIL stall_hold[%0d]: vld=%b result=%0d en=%b clr=%b required 1 64 0 0",
                         i, res_valid, result, en, clr_acc);
            end
        end
        start = 1'b0;
        handshake_to_idle("stall");
        step();
        vec_cnt++;
        if (busy !== 1'b0 || clr_acc !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_no_queue: busy=%b clr=%b required 0 0", busy, clr_acc);
        end
    endtask

    task automatic test_abort();
        start_and_run(100, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0 || en !== 1'b0 || res_valid !== 1'b0 || result !== 13'd64) begin
            err_cnt++;
            $display("FAIL abort_mid: busy=%b en=%b vld=%b result=%0d required 0 0 0 64",
                     busy, en, res_valid, result);
        end
        // Abort on the final RUN cycle must beat completion.
        start_and_run(255, 1'b1);
        add_out = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        add_out = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0 || en !== 1'b0 || res_valid !== 1'b0 || result !== 13'd64) begin
            err_cnt++;
            $display("FAIL abort_last: busy=%b en=%b vld=%b result=%0d required 0 0 0 64",
                     busy, en, res_valid, result);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vec_cnt++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL abort_quiet[%0d]: vld=%b busy=%b required 0 0", i, res_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ne, nen, nclr, nones;
        run_window(0, 1'b1, ne, nen, nclr, nones);
        vec_cnt++;
        if (result !== 13'd128) begin err_cnt++; $display("FAIL b2b_first: got %0d required 128", result); end
        res_ready = 1'b1;
        start = 1'b1;
        step();
        res_ready = 1'b0;
        start = 1'b0;
        vec_cnt++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_clear: vld=%b busy=%b required 0 1", res_valid, busy);
        end
        run_window(2, 1'b0, ne, nen, nclr, nones);
        vec_cnt++;
        if (result !== 13'd0) begin err_cnt++; $display("FAIL b2b_second: got %0d required 0", result); end
        vec_cnt++;
        if (ne !== 258) begin err_cnt++; $display("FAIL b2b_latency: got %0d required 258", ne); end
        handshake_to_idle("b2b");
    endtask

    task automatic test_rst_mid_run();
        int ne, nen, nclr, nones;
        start_and_run(50, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec_cnt++;
        if ({clr_acc, en, busy, res_valid} !== 4'b0000 || result !== '0) begin
            err_cnt++;
            $display("FAIL rst_mid: clr/en/busy/vld=%b result=%0d required 0000 0",
                     {clr_acc, en, busy, res_valid}, result);
        end
        run_window(0, 1'b1, ne, nen, nclr, nones);
        vec_cnt++;
        if (result !== 13'd128) begin err_cnt++; $display("FAIL rst_fresh: got %0d required 128", result); end
        handshake_to_idle("rst");
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_every_other();
        test_all_ones();
        test_stall();
        test_abort();
        test_back_to_back();
        test_rst_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
